// File: rtl/count_sequencer.sv
// count_sequencer: runs a WIDTH-bit counter through commanded one-shot or periodic
// runs with pause/stop. Optional tick prescaler enabled by COUNT_SEQUENCER_PRESCALE_EN.
module count_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
    input  logic             pause,
    input  logic             stop,
    input  logic [PRE_W-1:0] pre_div,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] limit_nxt;
    logic             periodic_r;
    logic             periodic_nxt;
    logic             tc_nxt;
    logic             done_nxt;
    logic             tick_c;
    logic             accept_c;

    assign accept_c = cmd_valid && cmd_ready;

`ifdef COUNT_SEQUENCER_PRESCALE_EN
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_nxt;

    // A tick fires when the prescaler reaches the live divisor value.
    assign tick_c = (pre_cnt == pre_div);

    always_comb begin
        pre_nxt = pre_cnt;
        case (state)
            IDLE: begin
                if (accept_c) pre_nxt = '0;
            end
            RUN: begin
                if (stop)        pre_nxt = '0;
                else if (!pause) pre_nxt = tick_c ? '0 : PRE_W'(pre_cnt + 1'b1);
            end
            HOLD: begin
                if (stop) pre_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre_cnt <= '0;
        else        pre_cnt <= pre_nxt;
    end
`else
    logic unused_pre_div;
    assign unused_pre_div = ^pre_div;
    assign tick_c         = 1'b1;
`endif

    // Next-state and next-output decode; stop > pause > terminal count > increment.
    always_comb begin
        state_nxt    = state;
        q_nxt        = q;
        limit_nxt    = limit_r;
        periodic_nxt = periodic_r;
        tc_nxt       = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    limit_nxt    = cmd_limit;
                    periodic_nxt = cmd_periodic;
                    q_nxt        = '0;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    q_nxt     = '0;
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else if (tick_c) begin
                    if (q == limit_r) begin
                        tc_nxt = 1'b1;
                        if (periodic_r) begin
                            q_nxt = '0;
                        end else begin
                            done_nxt  = 1'b1;
                            state_nxt = DONE;
                        end
                    end else begin
                        q_nxt = WIDTH'(q + 1'b1);
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    q_nxt     = '0;
                    state_nxt = IDLE;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; ready/busy are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            q          <= '0;
            limit_r    <= '0;
            periodic_r <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            q          <= q_nxt;
            limit_r    <= limit_nxt;
            periodic_r <= periodic_nxt;
            tc         <= tc_nxt;
            done       <= done_nxt;
            cmd_ready  <= (state_nxt == IDLE);
            busy       <= (state_nxt == RUN) || (state_nxt == HOLD);
        end
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that sequences a WIDTH-bit counter through programmed count runs: load limit, run, pause/resume, stop, terminal-count signalling.
- Accepts commands over a valid/ready handshake; supports one-shot and periodic (auto-reload) modes.
- Sits between a control master and the counter/timer datapath; produces the count value plus tc/done event pulses.

Parameters:
- WIDTH, 4, counter and limit width in bits.
- PRE_W, 4, prescaler divisor width; used only with the optional feature.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  master presents a command.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_limit  input  WIDTH  terminal count value; sampled on accept.
- cmd_periodic  input  1  1 = periodic auto-reload, 0 = one-shot; sampled on accept.
- pause  input  1  level; freezes counting while high.
- stop  input  1  level; aborts run, returns to IDLE.
- pre_div  input  PRE_W  tick divisor; ignored unless the optional feature is compiled in.
- q  output  WIDTH  current count.
- busy  output  1  high in RUN or HOLD.
- tc  output  1  registered one-cycle pulse per terminal count.
- done  output  1  registered one-cycle pulse on one-shot completion.

Behaviour:
- Reset (reset=0, async, any state): state=IDLE, q=0, latched limit=0, latched mode=one-shot, tc=0, done=0, cmd_ready=1, busy=0, prescaler=0. Takes effect immediately, including mid-run.
- States: IDLE, RUN, HOLD, DONE. Encoding is free; outputs are glitch-free registered or state-decoded.
- IDLE:
  - cmd_ready=1; q holds its last value.
  - Accept on cmd_valid&cmd_ready at a rising edge: latch limit and mode, q<=0, prescaler<=0, go RUN.
  - stop or pause in IDLE: ignored.
- RUN, on each count tick (every clk without the optional feature):
  - q!=limit: q<=q+1.
  - q==limit: tc=1 for the next cycle. Periodic: q<=0, stay RUN. One-shot: q holds limit, go DONE.
  - Period = limit+1 ticks. limit=0 is legal: periodic gives tc every tick; one-shot gives DONE after the first tick.
- RUN, pause=1 (no stop): go HOLD at the edge; no increment and no tc on that edge.
- HOLD: q and prescaler frozen. pause=0 returns to RUN at the edge; counting resumes on the following tick.
- stop=1 in RUN or HOLD: go IDLE, q<=0, no tc, no done.
- Same-edge priority: stop > pause > terminal count > increment.
- DONE: done=1 and tc=1 during this single cycle; q=limit; busy=0; cmd_ready=0; unconditionally go IDLE next edge.
- cmd_valid outside IDLE: ignored; the master holds it until cmd_ready.
- Arithmetic: unsigned modulo 2^WIDTH. Wrap cannot occur because reload happens at q==limit ≤ 2^WIDTH−1.

Optional Feature:
- COUNT_SEQUENCER_PRESCALE_EN defined:
  - A tick occurs in RUN once every pre_div+1 clk cycles. Prescaler counts 0..pre_div, then ticks and clears.
  - pre_div is sampled each cycle; a change takes effect at the next compare.
  - Prescaler clears on accept and on stop; freezes in HOLD.
  - pause/stop act on clk edges, not ticks.
- Not defined: every RUN cycle is a tick; pre_div is unused (port kept, no logic).

Test Plan:
- Reset mid-run: one-shot limit=9; drop reset at q=5 -> q=0, busy=0, cmd_ready=1 immediately, without waiting for a clk edge.
- One-shot limit=3 accepted at edge E0 -> q=1,2,3 after E1..E3; after E4 tc=1, done=1, q=3 for one cycle; after E5 cmd_ready=1; cmd_valid held high from E1 is not accepted before E5.
- Periodic limit=2 for 9 cycles after accept -> q sequence 1,2,0,1,2,0,1,2,0; tc high in cycles 3, 6, 9; done never high.
- Periodic limit=5, pause high for 3 cycles at q=2 -> q stays 2, busy=1, no tc; after release q=3 one cycle later; stop at q=4 with pause=1 on the same edge -> IDLE, q=0, no tc/done.
- limit=0: periodic gives tc every cycle with q=0; one-shot gives tc=done=1 one cycle after the first tick, then IDLE.
- With COUNT_SEQUENCER_PRESCALE_EN, pre_div=2, one-shot limit=1 -> q=1 after 3 cycles; tc/done 3 cycles later; pause during prescale freezes the prescaler.
